// File: rtl/wave_banner_seq.sv
// wave_banner_seq: steps a pattern RAM column by column onto a bank of row lines,
// holding each column a programmable number of cycles, with optional looping.
module wave_banner_seq #(
  parameter int ROWS     = 6,
  parameter int MAX_COLS = 64,
  parameter int CW       = 6,
  parameter int TW       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            loop_en,
  input  logic [CW:0]     num_cols,
  input  logic [TW-1:0]   ticks_per_col,
  input  logic            wr_en,
  input  logic [CW-1:0]   wr_addr,
  input  logic [ROWS-1:0] wr_data,
  output logic [ROWS-1:0] rows,
  output logic [CW-1:0]   col_idx,
  output logic            col_strobe,
  output logic            busy,
  output logic            done
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  localparam logic [CW:0] ONE = 1;
  state_t state_q, state_d;
  logic [ROWS-1:0] mem [MAX_COLS];
  logic [ROWS-1:0] rows_q, rows_d;
  logic [CW:0] col_q, col_d, ncols_q, ncols_d;
  logic [TW-1:0] tick_q, tick_d, t_q, t_d;
  logic strobe_q, strobe_d, busy_q, done_q;
  logic go, end_col, adv, end_sweep;
  assign go        = state_q == IDLE && start && num_cols != '0;
  assign end_col   = tick_q == t_q;
  assign adv       = state_q == RUN && end_col;
  assign end_sweep = adv && col_q == ncols_q - ONE;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rows_q   <= '0;
      col_q    <= '0;
      tick_q   <= '0;
      ncols_q  <= '0;
      t_q      <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rows_q   <= rows_d;
      col_q    <= col_d;
      tick_q   <= tick_d;
      ncols_q  <= ncols_d;
      t_q      <= t_d;
      strobe_q <= strobe_d;
      busy_q   <= state_d == RUN;
      done_q   <= state_d == FIN;
    end
  end
  // abort outranks both the column advance and the end of sweep
  always_comb begin
    state_d = state_q == IDLE ? (start ? (num_cols == '0 ? FIN : RUN) : IDLE) :
              state_q == RUN  ? (abort ? IDLE : (end_sweep && !loop_en) ? FIN : RUN) :
              IDLE;
  end
  // the fetch reads mem before any same-edge write lands, so a hazard returns old data
  always_comb begin
    ncols_d  = go ? num_cols : ncols_q;
    t_d      = go ? (ticks_per_col == '0 ? TW'(1) : ticks_per_col) : t_q;
    col_d    = (go || end_sweep) ? '0 : adv ? col_q + ONE : col_q;
    tick_d   = (go || adv) ? TW'(1) : tick_q + TW'(1);
    strobe_d = go || adv;
    rows_d   = (go || adv) ? mem[col_d[CW-1:0]] : rows_q;
    if (state_d != RUN) begin
      rows_d   = '0;
      col_d    = '0;
      tick_d   = '0;
      strobe_d = 1'b0;
    end
  end
  assign rows       = rows_q;
  assign col_idx    = col_q[CW-1:0];
  assign col_strobe = strobe_q;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule

// File: tb/tb_wave_banner_seq.sv
// tb_wave_banner_seq: directed sweeps with a per-cycle expected-output queue.
module tb_wave_banner_seq;
  typedef struct packed {
    logic [5:0] rows;
    logic [5:0] col;
    logic       stb;
    logic       busy;
    logic       done;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, loop_en = 1'b0, wr_en = 1'b0;
  logic [6:0] num_cols = '0;
  logic [7:0] ticks_per_col = '0;
  logic [5:0] wr_addr = '0, wr_data = '0;
  logic [5:0] rows, col_idx;
  logic col_strobe, busy, done;
  logic [5:0] shadow [64];
  exp_t q[$];
  int n_cmp = 0, n_err = 0, cyc = 0;
  always #5 clk = ~clk;
  wave_banner_seq dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .loop_en(loop_en),
    .num_cols(num_cols), .ticks_per_col(ticks_per_col),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rows(rows), .col_idx(col_idx), .col_strobe(col_strobe), .busy(busy), .done(done)
  );
  // an empty queue means the block must look idle
  task automatic step();
    exp_t e, o;
    @(posedge clk);
    #1;
    cyc++;
    e = '0;
    if (q.size() > 0) e = q.pop_front();
    o = {rows, col_idx, col_strobe, busy, done};
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL cyc%0d: observed rows=%b col=%0d stb=%b busy=%b done=%b expected rows=%b col=%0d stb=%b busy=%b done=%b",
             cyc, o.rows, o.col, o.stb, o.busy, o.done, e.rows, e.col, e.stb, e.busy, e.done);
    end
  endtask
  task automatic wr(input int a, input logic [5:0] d);
    wr_en = 1'b1;
    wr_addr = 6'(a);
    wr_data = d;
    shadow[a] = d;
    step();
    wr_en = 1'b0;
  endtask
  task automatic push_sweep(input int n, input int t, input bit fin);
    int tt = (t == 0) ? 1 : t;
    for (int k = 0; k < n; k++)
      for (int j = 0; j < tt; j++)
        q.push_back('{shadow[k], 6'(k), j == 0, 1'b1, 1'b0});
    if (fin) q.push_back('{6'd0, 6'd0, 1'b0, 1'b0, 1'b1});
  endtask
  initial begin
    // reset held 3 cycles with start and wr_en toggling
    for (int i = 0; i < 3; i++) begin
      start = !i[0];
      wr_en = i[0];
      wr_addr = 6'd63;
      wr_data = 6'h2a;
      step();
    end
    rst = 1'b0;
    start = 1'b0;
    wr_en = 1'b0;
    step();
    // basic sweep, with a start while busy that must be ignored
    wr(0, 6'b111111);
    wr(1, 6'b100100);
    wr(2, 6'b100100);
    wr(3, 6'b011011);
    num_cols = 7'd4;
    ticks_per_col = 8'd3;
    start = 1'b1;
    push_sweep(4, 3, 1);
    step();
    start = 1'b0;
    repeat (4) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    step();
    // ticks_per_col=0, start together with abort in IDLE
    wr(0, 6'b000001);
    wr(1, 6'b000010);
    num_cols = 7'd2;
    ticks_per_col = 8'd0;
    start = 1'b1;
    abort = 1'b1;
    push_sweep(2, 0, 1);
    step();
    start = 1'b0;
    abort = 1'b0;
    repeat (2) step();
    // start and abort in the FIN cycle: ignored, done already shown
    start = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    push_sweep(2, 0, 1);
    step();
    start = 1'b0;
    repeat (3) step();
    // loop then abort; setting changes while busy must not matter
    wr(2, 6'b110011);
    num_cols = 7'd3;
    ticks_per_col = 8'd2;
    loop_en = 1'b1;
    start = 1'b1;
    push_sweep(3, 2, 0);
    push_sweep(3, 2, 0);
    step();
    start = 1'b0;
    repeat (2) step();
    num_cols = 7'd5;
    ticks_per_col = 8'd7;
    repeat (7) step();
    abort = 1'b1;
    q.delete();
    step();
    abort = 1'b0;
    loop_en = 1'b0;
    repeat (4) step();
    // num_cols=0
    num_cols = 7'd0;
    ticks_per_col = 8'd3;
    start = 1'b1;
    q.push_back('{6'd0, 6'd0, 1'b0, 1'b0, 1'b1});
    step();
    start = 1'b0;
    repeat (2) step();
    // full depth, T=1
    for (int i = 0; i < 64; i++) wr(i, 6'($urandom));
    num_cols = 7'd64;
    ticks_per_col = 8'd1;
    start = 1'b1;
    push_sweep(64, 1, 1);
    step();
    start = 1'b0;
    repeat (64) step();
    step();
    // write hazard on the displayed column while looping
    wr(1, 6'b010101);
    num_cols = 7'd3;
    ticks_per_col = 8'd4;
    loop_en = 1'b1;
    start = 1'b1;
    push_sweep(3, 4, 0);
    step();
    start = 1'b0;
    repeat (4) step();
    wr(1, 6'b101010);
    push_sweep(3, 4, 0);
    repeat (7) step();
    loop_en = 1'b0;
    q.push_back('{6'd0, 6'd0, 1'b0, 1'b0, 1'b1});
    repeat (12) step();
    repeat (2) step();
    n_cmp++;
    assert (q.size() == 0) else begin
      n_err++;
      $error("FAIL q_drained: observed %0d left expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
